// File: rtl/dmem_pkg.sv
// Shared encodings, lane helpers and the response-register layout for the
// data-memory arbiter.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // What the arbiter remembers about a granted access until its response.
  typedef struct packed {
    logic       owner;  // 0 = port 0, 1 = port 1
    logic       we;
    logic [1:0] size;
    logic [1:0] off;
    logic       sext;
    logic       err;
  } rsp_t;

  // Byte-lane enables for a legal store of the given size at the given offset.
  function automatic logic [3:0] lane_wren(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Half on an odd byte, word off a word boundary, or the reserved size code.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        act,
  input  logic        wr,
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wren,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sext,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sext);
    logic signed [7:0] sb;
    sb = b;
    return sext ? 32'(sb) : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sext);
    logic signed [15:0] sh;
    sh = h;
    return sext ? 32'(sh) : {16'd0, h};
  endfunction

  // Replicate the right-justified store data across every lane it may land in.
  always_comb begin
    mem_wdata = '0;
    if (act) begin
      case (st_size)
        SZ_B:    mem_wdata = {4{st_data[7:0]}};
        SZ_H:    mem_wdata = {2{st_data[15:0]}};
        default: mem_wdata = st_data;
      endcase
    end
  end

  assign mem_wren = wr ? lane_wren(st_size, st_off) : 4'b0000;
  assign shifted  = mem_rdata >> {ld_off, 3'b000};

  // Bring the addressed byte/half down to bit 0 and extend it.
  always_comb begin
    case (ld_size)
      SZ_B:    ld_data = ext8(shifted[7:0], ld_sext);
      SZ_H:    ld_data = ext16(shifted[15:0], ld_sext);
      default: ld_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Port 0 is the load/store unit, port 1 the loader/debug port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_sext,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_sext,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wren,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              last;
  logic              act, sel, bad, wr, ld_ok;
  logic              w_we, w_sext;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] ld_data;
  logic              vld_p1;
  rsp_t              rsp_p1;

  // A lone requester wins; a tie goes to the port that did not win last.
  // Nothing is granted while reset is asserted, which also blocks writes.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (m0_req && (!m1_req || last)) m0_gnt = 1'b1;
      else if (m1_req)                 m1_gnt = 1'b1;
    end
  end

  assign act = m0_gnt | m1_gnt;
  assign sel = m1_gnt;

  // Forward the winner's request fields onto the shared memory path.
  always_comb begin
    w_we    = sel ? m1_we    : m0_we;
    w_size  = sel ? m1_size  : m0_size;
    w_sext  = sel ? m1_sext  : m0_sext;
    w_addr  = sel ? m1_addr  : m0_addr;
    w_wdata = sel ? m1_wdata : m0_wdata;
  end

  assign bad      = misaligned(w_size, w_addr[1:0]);
  assign wr       = act & w_we & ~bad;
  assign mem_addr = act ? {w_addr[ADDR_W-1:2], 2'b00} : '0;

  dmem_lane_align u_lane (
    .act       (act),
    .wr        (wr),
    .st_size   (w_size),
    .st_off    (w_addr[1:0]),
    .st_data   (w_wdata),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .ld_size   (rsp_p1.size),
    .ld_off    (rsp_p1.off),
    .ld_sext   (rsp_p1.sext),
    .mem_rdata (mem_rdata),
    .ld_data   (ld_data)
  );

  // Round-robin pointer follows the most recent winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last <= 1'b1;
    else if (act) last <= sel;
  end

  // ---- stage p0 -> p1: response valid, dropped on reset ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= act;
  end

  // Response payload, captured on grant; only meaningful while vld_p1 is set.
  always_ff @(posedge clk) begin
    if (act) rsp_p1 <= '{owner: sel, we: w_we, size: w_size, off: w_addr[1:0],
                         sext: w_sext, err: bad};
  end

  assign ld_ok     = ~rsp_p1.we & ~rsp_p1.err;
  assign m0_rvalid = vld_p1 & ~rsp_p1.owner;
  assign m1_rvalid = vld_p1 &  rsp_p1.owner;
  assign m0_err    = m0_rvalid & rsp_p1.err;
  assign m1_err    = m1_rvalid & rsp_p1.err;
  assign m0_rdata  = (m0_rvalid & ld_ok) ? ld_data : '0;
  assign m1_rdata  = (m1_rvalid & ld_ok) ? ld_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small registered-read memory model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_sext, m1_req, m1_we, m1_sext;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wren;

  int checks = 0;
  int fails  = 0;
  int proto_errs = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sext(m0_sext),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sext(m1_sext),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: each word initialised to C0DE0000 + byte address, read one cycle late.
  logic [31:0] mem [0:1023];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 + 32'(i * 4);
      mem_ready <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wren[b]) mem[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    mem_rdata <= mem[mem_addr[11:2]];
  end

  // Requests must not be withdrawn before they are granted.
  logic pend0 = 1'b0, pend1 = 1'b0;
  always @(posedge clk) begin
    if (pend0 && !m0_req && rst_n) begin
      proto_errs <= proto_errs + 1;
      $display("protocol: m0_req dropped without grant at %0t", $time);
    end
    if (pend1 && !m1_req && rst_n) begin
      proto_errs <= proto_errs + 1;
      $display("protocol: m1_req dropped without grant at %0t", $time);
    end
    pend0 <= m0_req && !m0_gnt && rst_n;
    pend1 <= m1_req && !m1_gnt && rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input int p, input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_req = 1'b1; m0_we = we; m0_size = size; m0_sext = sext; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_size = size; m1_sext = sext; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, SZ_W, 1'b0, 32'h4, 32'h0);
    repeat (2) @(negedge clk);
    #2;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin fails++; $display("FAIL rst_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin fails++; $display("FAIL rst_rsp: got %b want 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
    checks++; if ({mem_wren, mem_addr, mem_wdata} !== 68'h0) begin fails++; $display("FAIL rst_mem: wren %b addr %h wdata %h want all 0", mem_wren, mem_addr, mem_wdata); end
    rst_n = 1'b1;
    #2;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin fails++; $display("FAIL first_tie: got %b want 10", {m0_gnt, m1_gnt}); end
    @(posedge clk); #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin fails++; $display("FAIL first_rvalid: got %b want 10", {m0_rvalid, m1_rvalid}); end
    @(negedge clk); #2;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin fails++; $display("FAIL alt_1: got %b want 01", {m0_gnt, m1_gnt}); end
    @(negedge clk); #2;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin fails++; $display("FAIL alt_2: got %b want 10", {m0_gnt, m1_gnt}); end
    @(negedge clk); drop(0); #2;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin fails++; $display("FAIL alt_3: got %b want 01", {m0_gnt, m1_gnt}); end
    @(negedge clk); drop(1);
  endtask

  task automatic test_byte();
    @(negedge clk);
    drive(0, 1'b1, SZ_B, 1'b0, 32'h103, 32'h1234_56A5);
    #2;
    checks++; if (m0_gnt !== 1'b1) begin fails++; $display("FAIL sb_gnt: got %b want 1", m0_gnt); end
    checks++; if (mem_wren !== 4'b1000) begin fails++; $display("FAIL sb_wren: got %b want 1000", mem_wren); end
    checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata); end
    checks++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL sb_addr: got %h want 00000100", mem_addr); end
    @(posedge clk); #1;
    checks++; if ({m0_rvalid, m0_err, m0_rdata} !== {1'b1, 1'b0, 32'h0}) begin fails++; $display("FAIL sb_rsp: rvalid %b err %b rdata %h want 1 0 0", m0_rvalid, m0_err, m0_rdata); end
    @(negedge clk);
    drive(0, 1'b0, SZ_B, 1'b1, 32'h103, 32'h0);
    #2;
    checks++; if ({m0_gnt, mem_wren} !== 5'b1_0000) begin fails++; $display("FAIL lb_wren: gnt %b wren %b want 1 0000", m0_gnt, mem_wren); end
    @(posedge clk); #1;
    checks++; if (m0_rdata !== 32'hFFFF_FFA5) begin fails++; $display("FAIL lb_sext: got %h want ffffffa5", m0_rdata); end
    @(negedge clk);
    drive(0, 1'b0, SZ_B, 1'b0, 32'h103, 32'h0);
    @(posedge clk); #1;
    checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h0000_00A5}) begin fails++; $display("FAIL lb_zext: rvalid %b rdata %h want 1 000000a5", m0_rvalid, m0_rdata); end
    @(negedge clk); drop(0);
  endtask

  task automatic test_half();
    @(negedge clk);
    drive(1, 1'b1, SZ_H, 1'b0, 32'h202, 32'hFFFF_8001);
    #2;
    checks++; if ({m1_gnt, m0_gnt} !== 2'b10) begin fails++; $display("FAIL sh_gnt: got %b want 10", {m1_gnt, m0_gnt}); end
    checks++; if (mem_wren !== 4'b1100) begin fails++; $display("FAIL sh_wren: got %b want 1100", mem_wren); end
    checks++; if (mem_wdata !== 32'h8001_8001) begin fails++; $display("FAIL sh_wdata: got %h want 80018001", mem_wdata); end
    @(posedge clk); #1;
    checks++; if ({m1_rvalid, m0_rvalid, m1_rdata} !== {2'b10, 32'h0}) begin fails++; $display("FAIL sh_rsp: rvalid %b%b rdata %h want 10 0", m1_rvalid, m0_rvalid, m1_rdata); end
    @(negedge clk);
    drive(1, 1'b0, SZ_H, 1'b1, 32'h202, 32'h0);
    @(posedge clk); #1;
    checks++; if (m1_rdata !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_sext: got %h want ffff8001", m1_rdata); end
    @(negedge clk);
    drive(1, 1'b0, SZ_H, 1'b0, 32'h202, 32'h0);
    @(posedge clk); #1;
    checks++; if (m1_rdata !== 32'h0000_8001) begin fails++; $display("FAIL lh_zext: got %h want 00008001", m1_rdata); end
    @(negedge clk); drop(1);
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    drive(0, 1'b1, SZ_W, 1'b0, 32'h105, 32'hFFFF_FFFF);
    #2;
    checks++; if ({m0_gnt, mem_wren} !== 5'b1_0000) begin fails++; $display("FAIL mis_gnt_wren: gnt %b wren %b want 1 0000", m0_gnt, mem_wren); end
    @(posedge clk); #1;
    checks++; if ({m0_rvalid, m0_err, m0_rdata} !== {2'b11, 32'h0}) begin fails++; $display("FAIL mis_rsp: rvalid %b err %b rdata %h want 1 1 0", m0_rvalid, m0_err, m0_rdata); end
    @(negedge clk);
    drive(0, 1'b0, SZ_W, 1'b0, 32'h104, 32'h0);
    @(posedge clk); #1;
    checks++; if ({m0_err, m0_rdata} !== {1'b0, 32'hC0DE_0104}) begin fails++; $display("FAIL mis_nowrite: err %b rdata %h want 0 c0de0104", m0_err, m0_rdata); end
    @(negedge clk);
    drive(0, 1'b0, SZ_X, 1'b0, 32'h100, 32'h0);
    #2;
    checks++; if ({m0_gnt, mem_wren} !== 5'b1_0000) begin fails++; $display("FAIL sz11_gnt_wren: gnt %b wren %b want 1 0000", m0_gnt, mem_wren); end
    @(posedge clk); #1;
    checks++; if ({m0_rvalid, m0_err, m0_rdata} !== {2'b11, 32'h0}) begin fails++; $display("FAIL sz11_rsp: rvalid %b err %b rdata %h want 1 1 0", m0_rvalid, m0_err, m0_rdata); end
    checks++; if ({m1_rvalid, m1_err} !== 2'b00) begin fails++; $display("FAIL sz11_other: m1 rvalid %b err %b want 0 0", m1_rvalid, m1_err); end
    @(negedge clk); drop(0);
  endtask

  // Last winner going in is port 0, so the first tie here belongs to port 1.
  task automatic test_contention();
    int idx [2];
    int exp_p, ngnt;
    logic [31:0] exp_d, got;
    idx[0] = 0; idx[1] = 0; ngnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (idx[p] < 8) drive(p, 1'b0, SZ_W, 1'b0, 32'h300 + 32'(8 * idx[p] + 4 * p), 32'h0);
        else            drop(p);
      end
      exp_p = (k % 2 == 0) ? 1 : 0;
      exp_d = 32'hC0DE_0300 + 32'(8 * idx[exp_p] + 4 * exp_p);
      #2;
      if (m0_gnt || m1_gnt) ngnt++;
      checks++; if ({m1_gnt, m0_gnt} !== (exp_p == 1 ? 2'b10 : 2'b01)) begin fails++; $display("FAIL cont_gnt[%0d]: got %b%b want port %0d", k, m1_gnt, m0_gnt, exp_p); end
      @(posedge clk); #1;
      got = (exp_p == 1) ? m1_rdata : m0_rdata;
      checks++; if ({m1_rvalid, m0_rvalid} !== (exp_p == 1 ? 2'b10 : 2'b01)) begin fails++; $display("FAIL cont_rvalid[%0d]: got %b%b want port %0d", k, m1_rvalid, m0_rvalid, exp_p); end
      checks++; if (got !== exp_d) begin fails++; $display("FAIL cont_rdata[%0d]: got %h want %h", k, got, exp_d); end
      idx[exp_p]++;
    end
    @(negedge clk); drop(0); drop(1);
    checks++; if (ngnt !== 16) begin fails++; $display("FAIL cont_count: got %0d grants want 16", ngnt); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    drive(0, 1'b0, SZ_W, 1'b0, 32'h300, 32'h0);
    #2;
    checks++; if (m0_gnt !== 1'b1) begin fails++; $display("FAIL mf_gnt: got %b want 1", m0_gnt); end
    @(posedge clk);
    @(negedge clk);
    drop(0);
    rst_n = 1'b0;
    drive(1, 1'b1, SZ_W, 1'b0, 32'h300, 32'hDEAD_BEEF);
    #2;
    checks++; if ({m0_rvalid, m0_rdata} !== {1'b0, 32'h0}) begin fails++; $display("FAIL mf_drop: rvalid %b rdata %h want 0 0", m0_rvalid, m0_rdata); end
    checks++; if ({m1_gnt, mem_wren} !== 5'b0_0000) begin fails++; $display("FAIL mf_store_blocked: gnt %b wren %b want 0 0000", m1_gnt, mem_wren); end
    @(posedge clk); #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin fails++; $display("FAIL mf_quiet: rvalid %b%b want 00", m0_rvalid, m1_rvalid); end
    @(negedge clk);
    drive(0, 1'b0, SZ_W, 1'b0, 32'h300, 32'h0);
    drive(1, 1'b0, SZ_W, 1'b0, 32'h304, 32'h0);
    rst_n = 1'b1;
    #2;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin fails++; $display("FAIL mf_tie: got %b want 10", {m0_gnt, m1_gnt}); end
    @(posedge clk); #1;
    checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hC0DE_0300}) begin fails++; $display("FAIL mf_nowrite: rvalid %b rdata %h want 1 c0de0300", m0_rvalid, m0_rdata); end
    @(negedge clk); drop(0); #2;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin fails++; $display("FAIL mf_next: got %b want 01", {m0_gnt, m1_gnt}); end
    @(posedge clk); #1;
    checks++; if ({m1_rvalid, m1_rdata} !== {1'b1, 32'hC0DE_0304}) begin fails++; $display("FAIL mf_m1_rsp: rvalid %b rdata %h want 1 c0de0304", m1_rvalid, m1_rdata); end
    @(negedge clk); drop(1);
  endtask

  task automatic test_protocol();
    @(negedge clk);
    checks++; if (proto_errs !== 0) begin fails++; $display("FAIL req_protocol: got %0d drops want 0", proto_errs); end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_size = SZ_W; m0_sext = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_size = SZ_W; m1_sext = 1'b0; m1_addr = '0; m1_wdata = '0;
    test_reset();
    test_byte();
    test_half();
    test_misaligned();
    test_contention();
    test_reset_midflight();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
